// File: rtl/univ_shift_reg_fe_pkg.sv
// ============================================================================
// Module      : univ_shift_reg_fe_pkg
// Description : Mode encodings shared by the universal register and its users.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package univ_shift_reg_fe_pkg;

  localparam logic [1:0] M_HOLD = 2'b00;
  localparam logic [1:0] M_SHR  = 2'b01;
  localparam logic [1:0] M_SHL  = 2'b10;
  localparam logic [1:0] M_LOAD = 2'b11;

  typedef enum logic [1:0] {
    MODE_HOLD = M_HOLD,
    MODE_SHR  = M_SHR,
    MODE_SHL  = M_SHL,
    MODE_LOAD = M_LOAD
  } mode_e;

  localparam int W_MIN = 2;

endpackage

`default_nettype wire

// File: rtl/univ_shift_reg_fe_if.sv
// ============================================================================
// Module      : univ_shift_reg_fe_if
// Description : Control, data and serial signals of the universal register.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface univ_shift_reg_fe_if
  import univ_shift_reg_fe_pkg::*;
#(
  parameter int W = 4
);

  logic [1:0]   m;
  logic [W-1:0] d;
  logic         sr;
  logic         sl;
  logic [W-1:0] q;
  logic [W-1:0] q_;
  logic         so_r;
  logic         so_l;

  modport master (
    output m, d, sr, sl,
    input  q, q_, so_r, so_l
  );

  modport slave (
    input  m, d, sr, sl,
    output q, q_, so_r, so_l
  );

endinterface

`default_nettype wire

// File: rtl/univ_shift_reg_fe_cells.sv
// ============================================================================
// Module      : mux2 / dff_fe_clr
// Description : Leaf cells: 2:1 mux and falling-edge D flop with async clear.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mux2 (
  input  wire logic a,
  input  wire logic b,
  input  wire logic s,
  output logic      y
);

  assign y = s ? b : a;

endmodule

module dff_fe_clr #(
  parameter logic CLR_BIT = 1'b0
) (
  input  wire logic c,
  input  wire logic clr_,
  input  wire logic d,
  output logic      q
);

  logic r_q;

  // Clear is level-sensitive inside the block, so an edge while clr_ is low
  // (or coincident with its release) simply re-applies the clear value.
  always_ff @(negedge c or negedge clr_) begin
    if (!clr_) begin
      r_q <= CLR_BIT;
    end else begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/univ_shift_reg_fe.sv
// ============================================================================
// Module      : univ_shift_reg_fe
// Description : W-bit hold/shift-right/shift-left/load register, falling edge.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module univ_shift_reg_fe
  import univ_shift_reg_fe_pkg::*;
#(
  parameter int           W       = 4,
  parameter bit           ROTATE  = 1'b0,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  wire logic            c,
  input  wire logic            clr_,
  univ_shift_reg_fe_if.slave   bus
);

  logic [W-1:0] w_q;

  for (genvar i = 0; i < W; i++) begin : g_bit
    logic w_shr;
    logic w_shl;
    logic w_lo;
    logic w_hi;
    logic w_nxt;

    // Right-shift source: upper neighbour, or the serial/rotated bit at the MSB.
    if (i == W - 1) begin : g_shr_end
      if (ROTATE) begin : g_rot
        assign w_shr = w_q[0];
      end else begin : g_ser
        assign w_shr = bus.sr;
      end
    end else begin : g_shr_mid
      assign w_shr = w_q[i+1];
    end

    if (i == 0) begin : g_shl_end
      if (ROTATE) begin : g_rot
        assign w_shl = w_q[W-1];
      end else begin : g_ser
        assign w_shl = bus.sl;
      end
    end else begin : g_shl_mid
      assign w_shl = w_q[i-1];
    end

    // m[0] picks within {HOLD,SHR} and {SHL,LOAD}; m[1] picks between pairs.
    mux2 u_mux_lo (
      .a (w_q[i]),
      .b (w_shr),
      .s (bus.m[0]),
      .y (w_lo)
    );

    mux2 u_mux_hi (
      .a (w_shl),
      .b (bus.d[i]),
      .s (bus.m[0]),
      .y (w_hi)
    );

    mux2 u_mux_out (
      .a (w_lo),
      .b (w_hi),
      .s (bus.m[1]),
      .y (w_nxt)
    );

    dff_fe_clr #(
      .CLR_BIT (CLR_VAL[i])
    ) u_dff (
      .c    (c),
      .clr_ (clr_),
      .d    (w_nxt),
      .q    (w_q[i])
    );
  end

  assign bus.q    = w_q;
  assign bus.q_   = ~w_q;
  assign bus.so_r = w_q[0];
  assign bus.so_l = w_q[W-1];

endmodule

`default_nettype wire

// File: tb/tb_univ_shift_reg_fe.sv
// ============================================================================
// Module      : tb_univ_shift_reg_fe
// Description : Directed self-checking bench for the universal register.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_univ_shift_reg_fe;
  import univ_shift_reg_fe_pkg::*;

  logic c = 1'b1;
  always #5 c = ~c;

  logic clr_a = 1'b1;
  logic clr_b = 1'b0;
  logic clr_c = 1'b0;

  univ_shift_reg_fe_if #(.W(4)) bus_a ();
  univ_shift_reg_fe_if #(.W(4)) bus_b ();
  univ_shift_reg_fe_if #(.W(8)) bus_c ();

  univ_shift_reg_fe #(.W(4), .ROTATE(1'b0), .CLR_VAL(4'b0000)) u_dut_a (
    .c (c), .clr_ (clr_a), .bus (bus_a)
  );

  univ_shift_reg_fe #(.W(4), .ROTATE(1'b1), .CLR_VAL(4'b0000)) u_dut_b (
    .c (c), .clr_ (clr_b), .bus (bus_b)
  );

  univ_shift_reg_fe #(.W(8), .ROTATE(1'b0), .CLR_VAL(8'b0000_0101)) u_dut_c (
    .c (c), .clr_ (clr_c), .bus (bus_c)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic fall();
    @(negedge c);
    #1;
  endtask

  logic       sr_v   [3] = '{1'b1, 1'b0, 1'b0};
  logic       so_exp [3] = '{1'b1, 1'b1, 1'b0};
  logic [3:0] shr_exp[3] = '{4'b1101, 4'b0110, 4'b0011};
  logic [3:0] rot_exp[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [7:0] pat        = 8'h5B;

  initial begin
    bus_a.m = M_HOLD; bus_a.d = '0; bus_a.sr = 1'b0; bus_a.sl = 1'b0;
    bus_b.m = M_HOLD; bus_b.d = '0; bus_b.sr = 1'b0; bus_b.sl = 1'b0;
    bus_c.m = M_HOLD; bus_c.d = '0; bus_c.sr = 1'b0; bus_c.sl = 1'b0;

    // Clear pulsed mid clock-high: takes effect with no edge
    @(posedge c);
    #2;
    clr_a = 1'b0;
    #1;
    check("clr_q",    bus_a.q,    16'h0);
    check("clr_qn",   bus_a.q_,   16'hF);
    check("clr_so_r", bus_a.so_r, 16'h0);
    check("clr_so_l", bus_a.so_l, 16'h0);

    bus_a.m = M_LOAD;
    bus_a.d = 4'b1010;
    repeat (3) begin
      fall();
      check("clr_hold", bus_a.q, 16'h0);
    end

    // Release during c high, then load on the next falling edge
    @(posedge c);
    #1;
    clr_a   = 1'b1;
    bus_a.d = 4'b1011;
    check("pre_load", bus_a.q, 16'h0);
    fall();
    check("load",    bus_a.q,  16'hB);
    check("load_qn", bus_a.q_, 16'h4);

    bus_a.m = M_HOLD;
    bus_a.d = 4'b0000;
    @(posedge c);
    #1;
    check("rise_nochg", bus_a.q, 16'hB);
    repeat (3) begin
      fall();
      check("hold", bus_a.q, 16'hB);
    end

    bus_a.m = M_SHR;
    for (int i = 0; i < 3; i++) begin
      bus_a.sr = sr_v[i];
      #1;
      check("so_r", bus_a.so_r, 16'(so_exp[i]));
      fall();
      check("shr", bus_a.q, 16'(shr_exp[i]));
    end

    bus_a.m  = M_SHL;
    bus_a.sl = 1'b1;
    #1;
    check("so_l", bus_a.so_l, 16'h0);
    fall();
    check("shl",    bus_a.q,  16'h7);
    check("shl_qn", bus_a.q_, 16'h8);

    // Rotating instance: edges ignored while held in clear
    check("rot_clr", bus_b.q, 16'h0);
    @(posedge c);
    #1;
    clr_b   = 1'b1;
    bus_b.m = M_LOAD;
    bus_b.d = 4'b1000;
    fall();
    check("rot_load", bus_b.q, 16'h8);

    bus_b.m = M_SHL;
    for (int i = 0; i < 4; i++) begin
      bus_b.sl = ~bus_b.sl;
      fall();
      check("rotl", bus_b.q, 16'(rot_exp[i]));
    end

    fall();
    check("rotl_pre_clr", bus_b.q, 16'h1);
    #2;
    clr_b = 1'b0;
    #1;
    check("mid_clr_q",  bus_b.q,  16'h0);
    check("mid_clr_qn", bus_b.q_, 16'hF);

    // Release coincident with a falling edge must not load
    bus_b.m = M_LOAD;
    bus_b.d = 4'b1111;
    @(negedge c);
    clr_b <= 1'b1;
    #1;
    check("race", bus_b.q, 16'h0);
    fall();
    check("post_race", bus_b.q, 16'hF);

    // Wide instance with non-zero clear value
    check("w8_clr",   bus_c.q,  16'h05);
    check("w8_clrqn", bus_c.q_, 16'hFA);
    bus_c.m = M_LOAD;
    bus_c.d = 8'hFF;
    fall();
    check("w8_clr_ign", bus_c.q, 16'h05);

    @(posedge c);
    #1;
    clr_c   = 1'b1;
    bus_c.m = M_SHR;
    for (int k = 0; k < 8; k++) begin
      bus_c.sr = pat[k];
      fall();
      if (k == 0) begin
        check("w8_first", bus_c.q, 16'h82);
      end
    end
    check("w8_replace", bus_c.q,  16'h5B);
    check("w8_qn",      bus_c.q_, 16'hA4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
